// File: rtl/gen_mpfifo.sv
// ---------------------------------------------------------------------------
// gen_mpfifo : multi-port FIFO for the superscalar decode/issue path.
//
// Each cycle it accepts 0..PUSH_W entries and releases 0..POP_W entries.
// Pushes and pops are all-or-nothing. Both are judged against the state at
// the start of the cycle, so space freed by a pop cannot be used by a push
// in the same cycle. The head POP_W entries are read combinationally.
//
// Optional feature macro: GEN_MPFIFO_ERR_EN
//   When defined, this adds the err_sticky output. It is set after any
//   dropped push or ignored pop, and is cleared by RST or flush.
//
// Ports
//   CLK        in   clock, all state on rising edge
//   RST        in   synchronous reset, active-high
//   flush      in   synchronous clear of all entries (below RST in priority)
//   push_cnt   in   entries offered this cycle (slot 0 oldest)
//   data_push  in   PUSH_W slots of DW bits, slot k at [k*DW +: DW]
//   pop_cnt    in   entries consumed this cycle
//   data_pop   out  POP_W slots, slot k = entry at rd_ptr+k
//   pop_valid  out  min(count, POP_W)
//   free_cnt   out  DP - count
//   fifo_empty out  count == 0
//   fifo_full  out  count == DP
//   push_ack   out  push of a non-zero count will be accepted this cycle
//   err_sticky out  (GEN_MPFIFO_ERR_EN only) sticky drop/ignore flag
// ---------------------------------------------------------------------------
module gen_mpfifo #(
    parameter int DW     = 64,
    parameter int AW     = 4,
    parameter int PUSH_W = 2,
    parameter int POP_W  = 2,
    localparam int DP    = 2 ** AW,
    localparam int MAXW  = (PUSH_W > POP_W) ? PUSH_W : POP_W,
    localparam int CW    = $clog2(DP + 1),
    localparam int NW    = $clog2(MAXW + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 flush,
    input  logic [NW-1:0]        push_cnt,
    input  logic [DW*PUSH_W-1:0] data_push,
    input  logic [NW-1:0]        pop_cnt,
    output logic [DW*POP_W-1:0]  data_pop,
    output logic [NW-1:0]        pop_valid,
    output logic [CW-1:0]        free_cnt,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 push_ack
`ifdef GEN_MPFIFO_ERR_EN
    ,
    output logic                 err_sticky
`endif
);

    logic [DW-1:0]   r_mem [DP];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;

    logic [AW:0]     w_count;
    logic [NW-1:0]   w_pop_valid;
    logic            w_push_fit;
    logic            w_push_ok;
    logic            w_pop_ok;
    logic [PUSH_W-1:0] w_wr_en;
    logic [AW-1:0]   w_wr_addr [PUSH_W];
    logic [DW-1:0]   w_wr_data [PUSH_W];

    // The pointers carry one extra wrap bit, so full and empty are distinct.
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign free_cnt    = CW'(DP) - CW'(w_count);
    assign fifo_empty  = (w_count == '0);
    assign fifo_full   = (w_count == (AW+1)'(DP));
    assign w_pop_valid = (w_count >= (AW+1)'(POP_W)) ? NW'(POP_W) : NW'(w_count);
    assign pop_valid   = w_pop_valid;

    // An out-of-range push_cnt is treated the same as a push that does not fit.
    assign w_push_fit  = (push_cnt <= NW'(PUSH_W)) && (CW'(push_cnt) <= free_cnt);
    assign w_push_ok   = w_push_fit && !flush;
    assign push_ack    = (push_cnt != '0) && w_push_ok;
    assign w_pop_ok    = (pop_cnt <= w_pop_valid);

    // Per-slot write ports. The index addition wraps modulo DP, so a burst
    // that crosses index DP-1 lands in consecutive slots.
    for (genvar gi = 0; gi < PUSH_W; gi++) begin : g_wr
        assign w_wr_en[gi]   = w_push_ok && (push_cnt > NW'(gi));
        assign w_wr_addr[gi] = r_wr_ptr[AW-1:0] + AW'(gi);
        assign w_wr_data[gi] = data_push[gi*DW +: DW];
    end

    // Storage is not reset. Contents behind rd_ptr are don't-care.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < PUSH_W; k++) begin
            if (w_wr_en[k]) begin
                r_mem[w_wr_addr[k]] <= w_wr_data[k];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(push_cnt);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(pop_cnt);
            end
        end
    end

    // The head slots are read directly from storage, with no bypass from the
    // write ports. A new entry therefore appears one cycle after it is pushed.
    for (genvar gi = 0; gi < POP_W; gi++) begin : g_rd
        assign data_pop[gi*DW +: DW] = r_mem[r_rd_ptr[AW-1:0] + AW'(gi)];
    end

`ifdef GEN_MPFIFO_ERR_EN
    logic r_err_sticky;

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            r_err_sticky <= 1'b0;
        end else if (!w_push_fit || !w_pop_ok) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign err_sticky = r_err_sticky;
`endif

endmodule
